// File: rtl/vga_scanner.sv
// Raster timing generator for the dinorun display path: free-running h/v counters,
// one-stage registered sync, colour and per-frame tick outputs.
module vga_scanner #(
  parameter int          HVisible = 640,
  parameter int          HFront   = 16,
  parameter int          HSync    = 96,
  parameter int          HBack    = 48,
  parameter int          VVisible = 480,
  parameter int          VFront   = 10,
  parameter int          VSync    = 2,
  parameter int          VBack    = 33,
  parameter logic [11:0] FgColor  = 12'hFFF,
  parameter logic [11:0] BgColor  = 12'h000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [9:0] pixel_x_o,
  output logic [9:0] pixel_y_o,
  output logic       visible_o,
  input  logic       pixel_i,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [3:0] vga_red_o,
  output logic [3:0] vga_green_o,
  output logic [3:0] vga_blue_o,
  output logic       frame_tick_o
);

  localparam int HTotal = HVisible + HFront + HSync + HBack;
  localparam int VTotal = VVisible + VFront + VSync + VBack;

  if (HTotal > 1024 || VTotal > 1024) begin : g_bad_totals
    $error("vga_scanner: HTotal and VTotal must not exceed 1024");
  end

  // 11-bit constants so a sync window ending exactly at 1024 still compares correctly
  localparam logic [10:0] HLast     = 11'(HTotal - 1);
  localparam logic [10:0] VLast     = 11'(VTotal - 1);
  localparam logic [10:0] HVis      = 11'(HVisible);
  localparam logic [10:0] VVis      = 11'(VVisible);
  localparam logic [10:0] HSyncBeg  = 11'(HVisible + HFront);
  localparam logic [10:0] HSyncEnd  = 11'(HVisible + HFront + HSync);
  localparam logic [10:0] VSyncBeg  = 11'(VVisible + VFront);
  localparam logic [10:0] VSyncEnd  = 11'(VVisible + VFront + VSync);
  localparam logic [10:0] HTickX    = 11'(HVisible - 1);
  localparam logic [10:0] VTickY    = 11'(VVisible - 1);

  logic [9:0]  h_q, v_q;
  logic [10:0] h_ext, v_ext;
  logic        h_last, v_last;
  logic        visible;
  logic        hsync_d, vsync_d, tick_d;
  logic [11:0] color_d, color_q;

  assign h_ext  = {1'b0, h_q};
  assign v_ext  = {1'b0, v_q};
  assign h_last = (h_ext == HLast);
  assign v_last = (v_ext == VLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_last) begin
      h_q <= '0;
      if (v_last) v_q <= '0;
      else        v_q <= v_q + 10'd1;
    end else begin
      h_q <= h_q + 10'd1;
    end
  end

  assign pixel_x_o = h_q;
  assign pixel_y_o = v_q;
  assign visible   = (h_ext < HVis) && (v_ext < VVis);
  assign visible_o = visible;

  always_comb begin
    hsync_d = !((h_ext >= HSyncBeg) && (h_ext < HSyncEnd));
    vsync_d = !((v_ext >= VSyncBeg) && (v_ext < VSyncEnd));
    tick_d  = (h_ext == HTickX) && (v_ext == VTickY);
    // blanking is tested first so an unknown pixel_i cannot reach the colour register
    color_d = 12'h000;
    if (visible) begin
      if (pixel_i) color_d = FgColor;
      else         color_d = BgColor;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hsync_o      <= 1'b1;
      vsync_o      <= 1'b1;
      color_q      <= 12'h000;
      frame_tick_o <= 1'b0;
    end else begin
      hsync_o      <= hsync_d;
      vsync_o      <= vsync_d;
      color_q      <= color_d;
      frame_tick_o <= tick_d;
    end
  end

  assign vga_red_o   = color_q[11:8];
  assign vga_green_o = color_q[7:4];
  assign vga_blue_o  = color_q[3:0];

endmodule

// File: tb/tb_vga_scanner.sv
// Self-checking bench for vga_scanner on a shrunken raster (32x19) so whole frames
// stay short; an arithmetic model derives every expected output from the cycle count.
module tb_vga_scanner;

  localparam int HV = 20, HF = 3, HS = 5, HB = 4;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;   // 32
  localparam int VT = VV + VF + VS + VB;   // 19
  localparam int FR = HT * VT;             // 608
  localparam logic [11:0] FG = 12'hA5C;
  localparam logic [11:0] BG = 12'h312;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pixel = 1'b0;
  logic [9:0] px, py;
  logic       vis, hsync, vsync, tick;
  logic [3:0] red, green, blue;
  logic [11:0] col;

  assign col = {red, green, blue};

  always #5 clk = ~clk;

  vga_scanner #(
    .HVisible(HV), .HFront(HF), .HSync(HS), .HBack(HB),
    .VVisible(VV), .VFront(VF), .VSync(VS), .VBack(VB),
    .FgColor(FG), .BgColor(BG)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pixel_x_o(px), .pixel_y_o(py), .visible_o(vis),
    .pixel_i(pixel),
    .hsync_o(hsync), .vsync_o(vsync),
    .vga_red_o(red), .vga_green_o(green), .vga_blue_o(blue),
    .frame_tick_o(tick)
  );

  int   n_cmp = 0, n_err = 0;
  int   n = 0;          // clock edges since reset release
  int   cyc = 0;
  logic prev_pix = 1'b0;
  int   mode = 0;

  int   hs_run = 0, vs_run = 0;
  logic prev_hs = 1'b1, prev_vs = 1'b1;
  int   last_tick = -1, first_tick = -1, tick_cnt = 0, fg_cnt = 0;
  logic pos_chk = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    hs_run = 0; vs_run = 0; prev_hs = 1'b1; prev_vs = 1'b1;
    last_tick = -1; first_tick = -1;
  endtask

  task automatic compare_all();
    int   p, ph, pv, x, y;
    logic ehs, evs, etk;
    logic [11:0] ecol;
    x = n % HT;
    y = (n / HT) % VT;
    if (n == 0) begin
      ehs = 1'b1; evs = 1'b1; etk = 1'b0; ecol = 12'h000;
    end else begin
      p  = n - 1;
      ph = p % HT;
      pv = (p / HT) % VT;
      ehs  = !(ph >= HV + HF && ph < HV + HF + HS);
      evs  = !(pv >= VV + VF && pv < VV + VF + VS);
      etk  = (ph == HV - 1) && (pv == VV - 1);
      ecol = (ph < HV && pv < VV) ? (prev_pix ? FG : BG) : 12'h000;
    end
    chk("pixel_x", int'(px), x);
    chk("pixel_y", int'(py), y);
    chk("visible", int'(vis), int'(x < HV && y < VV));
    chk("hsync", int'(hsync), int'(ehs));
    chk("vsync", int'(vsync), int'(evs));
    chk("colour", int'(col), int'(ecol));
    chk("frame_tick", int'(tick), int'(etk));
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      n = n + 1;
      prev_pix = pixel;
    end
  end

  // compare process plus literal timing expectations that pin the model
  always @(negedge clk) begin
    compare_all();
    if (rst_n && n > 0) begin
      if (!hsync) begin
        if (prev_hs) chk("hsync_fall_x", int'(px), 24);
        hs_run++;
      end else if (hs_run > 0) begin
        chk("hsync_low_len", hs_run, 5);
        hs_run = 0;
      end
      if (!vsync) begin
        if (prev_vs) begin
          chk("vsync_fall_y", int'(py), 14);
          chk("vsync_fall_x", int'(px), 1);
        end
        vs_run++;
      end else if (vs_run > 0) begin
        chk("vsync_low_len", vs_run, 64);
        vs_run = 0;
      end
      prev_hs = hsync;
      prev_vs = vsync;
      if (tick) begin
        chk("tick_x", int'(px), 20);
        chk("tick_y", int'(py), 11);
        if (last_tick >= 0) chk("tick_period", cyc - last_tick, 608);
        if (first_tick < 0) first_tick = cyc;
        last_tick = cyc;
        tick_cnt++;
      end
      if (col == FG) begin
        fg_cnt++;
        if (pos_chk) chk("fg_pos_x", int'(px), 6);
      end
    end
  end

  task automatic drive_pix();
    case (mode)
      1:       pixel = 1'b1;
      2:       pixel = ((n % HT) == 5);
      default: pixel = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run(input int cycles, input int m);
    mode = m;
    repeat (cycles) begin
      @(negedge clk);
      #2;
      drive_pix();
    end
  endtask

  initial begin
    int rel;
    bit found;
    #1 rst_n = 1'b0;
    run(4, 0);

    @(negedge clk);
    #2;
    clear_stats();
    mode = 0;
    drive_pix();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_edge_x", int'(px), 1);
    chk("first_edge_y", int'(py), 0);

    tick_cnt = 0;
    run(2 * FR, 0);
    chk("ticks_in_2_frames", tick_cnt, 2);

    run(FR, 1);
    fg_cnt = 0;
    run(FR, 1);
    chk("fg_count_const_pixel", fg_cnt, 240);

    run(FR, 2);
    fg_cnt = 0;
    pos_chk = 1'b1;
    run(FR, 2);
    pos_chk = 1'b0;
    chk("fg_count_single_x", fg_cnt, 12);

    found = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      if ((n % HT) == 10 && ((n / HT) % VT) == 5) begin
        found = 1'b1;
        break;
      end
      run(1, 1);
    end
    chk("mid_reset_point_reached", int'(found), 1);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    n = 0;
    clear_stats();
    #1;
    chk("async_rst_x", int'(px), 0);
    chk("async_rst_y", int'(py), 0);
    chk("async_rst_hsync", int'(hsync), 1);
    chk("async_rst_vsync", int'(vsync), 1);
    chk("async_rst_colour", int'(col), 0);
    chk("async_rst_tick", int'(tick), 0);
    run(3, 1);

    @(negedge clk);
    #2;
    mode = 0;
    drive_pix();
    rst_n = 1'b1;
    first_tick = -1;
    rel = cyc;
    run(FR, 0);
    chk("tick_after_reset", first_tick - rel, 372);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
